// File: rtl/raid_array_if.sv
// Host and drive-side signal bundle for raid_array; the slave modport is the
// array controller's view, the master modport is the host/drive model's view.
interface raid_array_if #(
  parameter int NDRIVES = 4,
  parameter int LANE_W  = 8
);
  localparam int DW = NDRIVES * LANE_W;

  logic               read_en;
  logic               write_en;
  logic [31:0]        addr;
  logic [DW-1:0]      din;
  logic [3:0]         raid_type;
  logic [NDRIVES-1:0] failed_mask;
  logic [DW-1:0]      dout;
  logic               dout_valid;
  logic               busy;
  logic               parity;
  logic               err;
  logic               w_drives;
  logic               r_drives;
  logic [31:0]        drive_addr;
  logic [NDRIVES-1:0] drive_busy;
  logic [DW-1:0]      r_drive_data;
  logic [DW-1:0]      w_drive_data;

  modport slave (
    input  read_en, write_en, addr, din, raid_type, failed_mask,
           drive_busy, r_drive_data,
    output dout, dout_valid, busy, parity, err, w_drives, r_drives,
           drive_addr, w_drive_data
  );

  modport master (
    output read_en, write_en, addr, din, raid_type, failed_mask,
           drive_busy, r_drive_data,
    input  dout, dout_valid, busy, parity, err, w_drives, r_drives,
           drive_addr, w_drive_data
  );
endinterface

// File: rtl/raid_array.sv
// RAID0/RAID1/RAID5 request controller: one host request at a time is
// striped, mirrored or parity-encoded across NDRIVES lanes of LANE_W bits.
module raid_array #(
  parameter int NDRIVES = 4,
  parameter int LANE_W  = 8,
  parameter int TIMEOUT = 1024
) (
  input logic         clk,
  input logic         reset,
  raid_array_if.slave bus
);
  localparam int DW = NDRIVES * LANE_W;
  localparam int PW = $clog2(NDRIVES);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [3:0] MODE_RAID1 = 4'd0;
  localparam logic [3:0] MODE_RAID0 = 4'd1;
  localparam logic [3:0] MODE_RAID5 = 4'd5;

  typedef enum logic [2:0] {IDLE, ISSUE_W, WAIT_W, ISSUE_R, WAIT_R} state_t;

  state_t            r_state, w_next;
  logic              r_busy, r_dout_valid, r_err, r_par, r_seen;
  logic [31:0]       r_addr;
  logic [DW-1:0]     r_din, r_dout;
  logic [3:0]        r_type;
  logic [CW-1:0]     r_cnt;
  logic              w_accept, w_done, w_tmo, w_sup, w_eff_busy, w_found;
  logic              w_rerr, w_rpar;
  logic [PW-1:0]     w_p, w_wd, w_rd;
  logic [LANE_W-1:0] w_wx, w_rx, w_val;
  logic [DW-1:0]     w_wenc, w_rdata;
  logic [LANE_W-1:0] w_lane [NDRIVES];
  logic [LANE_W-1:0] w_fix  [NDRIVES];
  int unsigned       w_nfail, w_cnt1;

  assign w_p        = r_addr[PW-1:0];
  assign w_sup      = (r_type == MODE_RAID0) || (r_type == MODE_RAID1) || (r_type == MODE_RAID5);
  assign w_eff_busy = |(bus.drive_busy & ~bus.failed_mask);

  // Write lane encoding from the registered request.
  always_comb begin
    w_wenc = '0;
    w_wx   = '0;
    w_wd   = '0;
    case (r_type)
      MODE_RAID0: w_wenc = r_din;
      MODE_RAID1:
        for (int unsigned i = 0; i < NDRIVES; i++)
          w_wenc[i*LANE_W +: LANE_W] = r_din[LANE_W-1:0];
      MODE_RAID5: begin
        for (int unsigned k = 0; k < NDRIVES - 1; k++) begin
          w_wd = (PW'(k) < w_p) ? PW'(k) : PW'(k + 1);
          w_wenc[w_wd*LANE_W +: LANE_W] = r_din[k*LANE_W +: LANE_W];
          w_wx = w_wx ^ r_din[k*LANE_W +: LANE_W];
        end
        w_wenc[w_p*LANE_W +: LANE_W] = w_wx;
      end
      default: ;
    endcase
  end

  // Read decode; w_rx is the XOR of live lanes, which doubles as the
  // reconstruction of a single failed lane.
  always_comb begin
    w_nfail = 0;
    w_cnt1  = 0;
    w_rx    = '0;
    w_found = 1'b0;
    w_val   = '0;
    w_rd    = '0;
    w_rdata = '0;
    w_rerr  = 1'b0;
    w_rpar  = 1'b0;
    for (int unsigned i = 0; i < NDRIVES; i++) begin
      w_lane[i] = bus.r_drive_data[i*LANE_W +: LANE_W];
      if (bus.failed_mask[i]) w_nfail++;
      else                    w_rx = w_rx ^ w_lane[i];
    end
    for (int unsigned i = 0; i < NDRIVES; i++)
      w_fix[i] = bus.failed_mask[i] ? w_rx : w_lane[i];
    case (r_type)
      MODE_RAID0:
        if (|bus.failed_mask) begin
          w_rerr  = 1'b1;
          w_rdata = '1;
        end else begin
          w_rdata = bus.r_drive_data;
        end
      MODE_RAID1: begin
        for (int unsigned j = 0; j < NDRIVES; j++) begin
          if (!bus.failed_mask[j] && !w_found) begin
            w_cnt1 = 0;
            for (int unsigned i = 0; i < NDRIVES; i++)
              if (!bus.failed_mask[i] && (w_lane[i] == w_lane[j])) w_cnt1++;
            if (2 * w_cnt1 > NDRIVES - w_nfail) begin
              w_found = 1'b1;
              w_val   = w_lane[j];
            end
          end
        end
        if (w_found) begin
          w_rdata = DW'(w_val);
        end else begin
          w_rerr  = 1'b1;
          w_rdata = '1;
        end
      end
      MODE_RAID5:
        if (w_nfail >= 2) begin
          w_rerr  = 1'b1;
          w_rdata = '1;
        end else begin
          w_rpar = (w_nfail == 0) && (|w_rx);
          for (int unsigned k = 0; k < NDRIVES - 1; k++) begin
            w_rd = (PW'(k) < w_p) ? PW'(k) : PW'(k + 1);
            w_rdata[k*LANE_W +: LANE_W] = w_fix[w_rd];
          end
        end
      default: ;
    endcase
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_done   = 1'b0;
    w_tmo    = 1'b0;
    case (r_state)
      IDLE:
        if (!r_busy && (bus.read_en ^ bus.write_en)) begin
          w_accept = 1'b1;
          w_next   = bus.write_en ? ISSUE_W : ISSUE_R;
        end
      ISSUE_W: w_next = w_sup ? WAIT_W : IDLE;
      ISSUE_R: w_next = w_sup ? WAIT_R : IDLE;
      WAIT_W, WAIT_R: begin
        w_done = !w_eff_busy && (r_seen || (r_cnt >= CW'(2)));
        w_tmo  = !w_done && (r_cnt == CW'(TIMEOUT - 1));
        if (w_done || w_tmo) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_busy       <= 1'b1;
      r_addr       <= '0;
      r_din        <= '0;
      r_type       <= '0;
      r_cnt        <= '0;
      r_seen       <= 1'b0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_err        <= 1'b0;
      r_par        <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_busy       <= (w_next != IDLE);
      r_dout_valid <= 1'b0;
      if (w_accept) begin
        r_addr <= bus.addr;
        r_din  <= bus.din;
        r_type <= bus.raid_type;
        r_err  <= 1'b0;
        r_par  <= 1'b0;
      end
      case (r_state)
        ISSUE_W, ISSUE_R: begin
          r_cnt  <= CW'(1);
          r_seen <= 1'b0;
          if (!w_sup) begin
            r_err <= 1'b1;
            if (r_state == ISSUE_R) begin
              r_dout_valid <= 1'b1;
              r_dout       <= '0;
            end
          end
        end
        WAIT_W, WAIT_R: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_eff_busy) r_seen <= 1'b1;
          if (w_done) begin
            if (r_state == WAIT_R) begin
              r_dout       <= w_rdata;
              r_err        <= w_rerr;
              r_par        <= w_rpar;
              r_dout_valid <= 1'b1;
            end else if ((r_type == MODE_RAID0) && (|bus.failed_mask)) begin
              r_err <= 1'b1;
            end
          end else if (w_tmo) begin
            r_err <= 1'b1;
            if (r_state == WAIT_R) begin
              r_dout       <= '1;
              r_dout_valid <= 1'b1;
            end
          end
        end
        default: begin
          r_cnt  <= '0;
          r_seen <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy         = r_busy;
  assign bus.dout         = r_dout;
  assign bus.dout_valid   = r_dout_valid;
  assign bus.err          = r_err;
  assign bus.parity       = r_par;
  assign bus.drive_addr   = r_addr;
  assign bus.w_drives     = (r_state == ISSUE_W) && w_sup;
  assign bus.r_drives     = (r_state == ISSUE_R) && w_sup;
  assign bus.w_drive_data = (((r_state == ISSUE_W) && w_sup) || (r_state == WAIT_W)) ? w_wenc : '0;
endmodule

// File: tb/tb_raid_array.sv
// Self-checking bench for raid_array: directed scenarios plus randomized
// requests compared against a queue-based behavioural model.
module tb_raid_array;
  localparam int ND  = 4;
  localparam int LW  = 8;
  localparam int DW  = ND * LW;
  localparam int TMO = 16;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic [DW-1:0] last_dout;

  raid_array_if #(.NDRIVES(ND), .LANE_W(LW)) bus ();

  raid_array #(.NDRIVES(ND), .LANE_W(LW), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] m_write(input logic [3:0] t, input logic [31:0] a,
                                            input logic [DW-1:0] d);
    logic [LW-1:0] q[$];
    logic [LW-1:0] x;
    logic [DW-1:0] r;
    r = '0;
    case (t)
      4'd1: r = d;
      4'd0: for (int i = 0; i < ND; i++) r[i*LW +: LW] = d[LW-1:0];
      4'd5: begin
        x = '0;
        for (int i = 0; i < ND - 1; i++) begin
          q.push_back(d[i*LW +: LW]);
          x = x ^ d[i*LW +: LW];
        end
        q.insert(int'(a % 32'(ND)), x);
        for (int i = 0; i < ND; i++) r[i*LW +: LW] = q[i];
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic void m_read(input logic [3:0] t, input logic [31:0] a,
                                 input logic [DW-1:0] rd, input logic [ND-1:0] fm,
                                 output logic [DW-1:0] o, output logic e, output logic p);
    logic [LW-1:0] l[ND];
    logic [LW-1:0] q[$];
    logic [LW-1:0] x;
    int nf, nlive, c;
    bit found;
    o = '0; e = 1'b0; p = 1'b0;
    nf = $countones(fm);
    nlive = ND - nf;
    for (int i = 0; i < ND; i++) l[i] = rd[i*LW +: LW];
    case (t)
      4'd1: if (nf != 0) begin o = '1; e = 1'b1; end else o = rd;
      4'd0: begin
        found = 1'b0;
        for (int j = 0; j < ND; j++) begin
          if (!fm[j] && !found) begin
            c = 0;
            for (int i = 0; i < ND; i++) if (!fm[i] && l[i] == l[j]) c++;
            if (2 * c > nlive) begin found = 1'b1; o[LW-1:0] = l[j]; end
          end
        end
        if (!found) begin o = '1; e = 1'b1; end
      end
      4'd5: begin
        if (nf >= 2) begin
          o = '1; e = 1'b1;
        end else begin
          x = '0;
          for (int i = 0; i < ND; i++) if (!fm[i]) x = x ^ l[i];
          for (int i = 0; i < ND; i++) q.push_back(fm[i] ? x : l[i]);
          if (nf == 0) p = (x != '0);
          q.delete(int'(a % 32'(ND)));
          for (int i = 0; i < ND - 1; i++) o[i*LW +: LW] = q[i];
        end
      end
      default: begin o = '0; e = 1'b1; end
    endcase
  endfunction

  task automatic txn(input bit wr, input logic [3:0] t, input logic [31:0] a,
                     input logic [DW-1:0] d, input logic [ND-1:0] fm,
                     input logic [DW-1:0] rd, input logic [ND-1:0] bp, input int bc);
    int k, lat, elat, nstb, nbad, ndv;
    bit sup, eff, timed;
    logic [DW-1:0] wdat, eo;
    logic [31:0] adr;
    logic ee, ep;
    sup   = (t == 4'd0) || (t == 4'd1) || (t == 4'd5);
    eff   = ((bp & ~fm) != '0) && (bc > 0);
    timed = sup && eff && (bc >= TMO - 1);
    if (!sup)       elat = 2;
    else if (timed) elat = TMO + 1;
    else if (eff)   elat = (bc + 3 > 4) ? bc + 3 : 4;
    else            elat = 4;
    if (wr) begin
      eo = last_dout; ep = 1'b0;
      ee = !sup || timed || (t == 4'd1 && fm != '0);
    end else if (!sup) begin
      eo = '0; ee = 1'b1; ep = 1'b0;
    end else if (timed) begin
      eo = '1; ee = 1'b1; ep = 1'b0;
    end else begin
      m_read(t, a, rd, fm, eo, ee, ep);
    end

    for (int g = 0; g < 100 && bus.busy; g++) begin @(posedge clk); #1; end
    check("pre_idle", 128'(bus.busy), 128'(0));
    @(negedge clk);
    bus.read_en = !wr; bus.write_en = wr; bus.raid_type = t; bus.addr = a;
    bus.din = d; bus.failed_mask = fm; bus.r_drive_data = rd; bus.drive_busy = '0;
    @(posedge clk); #1;
    bus.read_en = 1'b0; bus.write_en = 1'b0;
    k = 1; lat = 0; nstb = 0; nbad = 0; ndv = 0; wdat = '0; adr = '0;
    while (k <= 60) begin
      if (bus.w_drives) begin
        if (wr) begin nstb++; wdat = bus.w_drive_data; adr = bus.drive_addr; end else nbad++;
      end
      if (bus.r_drives) begin
        if (!wr) begin nstb++; adr = bus.drive_addr; end else nbad++;
      end
      if (bus.dout_valid) ndv++;
      if (!bus.busy) begin lat = k; break; end
      bus.drive_busy = (k >= 2 && k <= bc + 1) ? bp : '0;
      @(posedge clk); #1;
      k++;
    end
    bus.drive_busy = '0;
    check("latency", 128'(lat), 128'(elat));
    check("strobes", 128'(nstb), 128'(sup ? 1 : 0));
    check("wrong_strobe", 128'(nbad), 128'(0));
    if (sup) check("drive_addr", 128'(adr), 128'(a));
    if (wr && sup) check("w_drive_data", 128'(wdat), 128'(m_write(t, a, d)));
    check("wdata_zeroed", 128'(bus.w_drive_data), 128'(0));
    check("dout_valid", 128'(ndv), 128'(wr ? 0 : 1));
    check("dout", 128'(bus.dout), 128'(eo));
    check("err", 128'(bus.err), 128'(ee));
    check("parity", 128'(bus.parity), 128'(ep));
    last_dout = eo;
    @(posedge clk); #1;
    check("dv_one_cycle", 128'(bus.dout_valid), 128'(0));
    check("dout_hold", 128'(bus.dout), 128'(last_dout));
  endtask

  initial begin
    logic [LW-1:0] v0, v1;
    logic [DW-1:0] rd, d;
    logic [ND-1:0] fm;
    logic [3:0] t;
    int sel;
    checks = 0; failures = 0; last_dout = '0;
    clk = 1'b0; reset = 1'b1;
    bus.read_en = 1'b0; bus.write_en = 1'b0; bus.addr = '0; bus.din = '0;
    bus.raid_type = '0; bus.failed_mask = '0; bus.drive_busy = '0; bus.r_drive_data = '0;

    #12;
    check("reset_busy", 128'(bus.busy), 128'(1));
    check("reset_outs", {bus.dout, bus.dout_valid, bus.parity, bus.err, bus.w_drives,
                         bus.r_drives, bus.drive_addr, bus.w_drive_data}, 128'(0));
    @(negedge clk); reset = 1'b0; #1;
    check("busy_held_after_release", 128'(bus.busy), 128'(1));
    @(posedge clk); #1;
    check("busy_falls", 128'(bus.busy), 128'(0));

    txn(1, 4'd1, 32'h0, 32'h44332211, 4'b0000, '0, '0, 0);
    txn(1, 4'd5, 32'h1, 32'h00070301, 4'b0000, '0, '0, 0);
    txn(0, 4'd5, 32'h1, '0, 4'b0100, 32'h07EE0501, '0, 0);
    txn(0, 4'd0, 32'h0, '0, 4'b0000, 32'hA55A5A5A, '0, 0);
    txn(0, 4'd0, 32'h0, '0, 4'b0000, 32'hA5A55A5A, '0, 0);
    txn(0, 4'd0, 32'h0, '0, 4'b0000, 32'h5A5A5A5A, 4'b0001, 1000);
    txn(0, 4'd5, 32'h2, '0, 4'b0000, 32'h01020304, '0, 0);
    txn(0, 4'd5, 32'h3, '0, 4'b0011, 32'h01020304, '0, 0);
    txn(0, 4'd3, 32'h0, '0, 4'b0000, 32'h12345678, '0, 0);
    txn(1, 4'd9, 32'h0, 32'hDEADBEEF, 4'b0000, '0, '0, 0);
    txn(1, 4'd1, 32'h8, 32'hCAFEF00D, 4'b0010, '0, '0, 0);
    txn(0, 4'd1, 32'h4, '0, 4'b0000, 32'h89ABCDEF, 4'b1111, 3);
    txn(0, 4'd1, 32'h4, '0, 4'b0000, 32'h89ABCDEF, 4'b0100, 14);
    txn(1, 4'd0, 32'h5, 32'h000000C3, 4'b1111, '0, 4'b1111, 5);

    @(negedge clk);
    bus.read_en = 1'b1; bus.write_en = 1'b1; bus.raid_type = 4'd1;
    @(posedge clk); #1;
    check("both_en_ignored", {bus.busy, bus.w_drives, bus.r_drives}, 128'(0));
    bus.read_en = 1'b0; bus.write_en = 1'b0;

    @(negedge clk);
    bus.write_en = 1'b1; bus.raid_type = 4'd1; bus.addr = 32'h77; bus.din = 32'h11223344;
    bus.failed_mask = '0;
    @(posedge clk); #1;
    bus.write_en = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1; #1;
    check("midop_reset_busy", 128'(bus.busy), 128'(1));
    check("midop_reset_outs", {bus.dout, bus.dout_valid, bus.parity, bus.err, bus.w_drives,
                               bus.r_drives, bus.drive_addr, bus.w_drive_data}, 128'(0));
    last_dout = '0;
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    check("busy_falls_2", 128'(bus.busy), 128'(0));
    txn(0, 4'd1, 32'h9, '0, 4'b0000, 32'h0F1E2D3C, '0, 0);

    for (int n = 0; n < 40; n++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 3)      t = 4'd1;
      else if (sel < 6) t = 4'd0;
      else if (sel < 9) t = 4'd5;
      else              t = 4'($urandom_range(6, 15));
      case ($urandom_range(0, 3))
        1:       fm = 4'(1 << $urandom_range(0, 3));
        2:       fm = 4'($urandom);
        default: fm = '0;
      endcase
      v0 = 8'($urandom); v1 = 8'($urandom);
      rd = $urandom;
      if (t == 4'd0)
        for (int i = 0; i < ND; i++) rd[i*LW +: LW] = $urandom_range(0, 2) != 0 ? v0 : v1;
      d = $urandom;
      txn(bit'($urandom_range(0, 1)), t, $urandom, d, fm, rd,
          4'($urandom), int'($urandom_range(0, 4)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
